// File: rtl/osd_dii_demux_n.sv
// ---------------------------------------------------------------------------
// osd_dii_demux_n -- routes DII packets to one of NOUT output channels.
//
// The first SEL_WORD+1 flits of every packet are held in a small header
// buffer. Bits [15:14] of word SEL_WORD select a packet type; ROUTE_TABLE
// maps the type to an output channel (2 bits per type). A channel index
// >= NOUT drops the whole packet. Packets that end before word SEL_WORD
// go to SHORT_PORT. Once the channel is known, the buffer streams
// through to that channel at up to one flit per cycle.
//
// Optional feature:
//   OSD_DEMUX_DROP_CNT_EN -- adds the drop_count port, a saturating count
//                            of dropped packets.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   in_data/last/valid/ready     input flit stream
//   out_data  [NOUT*16]  channel k at [16k+15:16k], all mirror buffer head
//   out_last  [NOUT]     per-channel last (mirrors buffer head)
//   out_valid [NOUT]     per-channel valid, at most one set
//   out_ready [NOUT]     per-channel ready
//   drop_count [16]      dropped-packet count (feature macro only)
// ---------------------------------------------------------------------------

// Per-channel output slice: qualifies the shared buffer head with the
// channel-select and reports when this channel takes a flit.
module osd_dii_demux_n_lane (
    input  logic        active,
    input  logic        head_valid,
    input  logic [15:0] head_data,
    input  logic        head_last,
    input  logic        ready,
    output logic        valid,
    output logic [15:0] data,
    output logic        last,
    output logic        take
);
    assign valid = active & head_valid;
    assign data  = head_data;
    assign last  = head_last;
    assign take  = valid & ready;
endmodule

module osd_dii_demux_n #(
    parameter int         NOUT        = 2,
    parameter int         SEL_WORD    = 2,
    parameter logic [7:0] ROUTE_TABLE = 8'h54,
    parameter int         SHORT_PORT  = NOUT - 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [15:0]          in_data,
    input  logic                 in_last,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [NOUT*16-1:0]   out_data,
    output logic [NOUT-1:0]      out_last,
    output logic [NOUT-1:0]      out_valid,
    input  logic [NOUT-1:0]      out_ready
`ifdef OSD_DEMUX_DROP_CNT_EN
    ,
    output logic [15:0]          drop_count
`endif
);
    localparam int DEPTH = SEL_WORD + 1;
    localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW    = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {COLLECT, STREAM, DROP} state_t;

    typedef struct packed {
        logic [15:0] data;
        logic        last;
    } flit_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    flit_t          mem [DEPTH];
    logic [PW-1:0]  rd_ptr;
    logic [PW-1:0]  wr_ptr;
    logic [CW-1:0]  count;
    logic [1:0]     port_q;
    // Set once the packet's last flit is accepted; blocks further input
    // until that flit has left the buffer (or the drop has finished).
    logic           last_seen;
    state_t         state;

    // ------------------------------------------------------------------
    // Datapath helpers
    // ------------------------------------------------------------------
    flit_t          head;
    logic           full;
    logic           empty;
    logic           push;
    logic           pop;
    logic           at_sel;
    logic [1:0]     sel_type;
    logic [1:0]     lut_port;
    logic           lut_drop;
    logic           streaming;
    logic [NOUT-1:0] take;

    assign head      = mem[rd_ptr];
    assign full      = (count == CW'(DEPTH));
    assign empty     = (count == '0);
    assign streaming = (state == STREAM) && !rst;

    // In COLLECT nothing pops, so the fill level is the index of the
    // word currently being offered.
    assign at_sel    = (count == CW'(SEL_WORD));
    assign sel_type  = in_data[15:14];
    assign lut_port  = ROUTE_TABLE[{sel_type, 1'b0} +: 2];
    assign lut_drop  = (int'(lut_port) >= NOUT);

    always_comb begin
        in_ready = 1'b0;
        if (!rst) begin
            unique case (state)
                COLLECT: in_ready = !full;
                STREAM:  in_ready = (!full || pop) && !last_seen;
                DROP:    in_ready = !last_seen;
                default: in_ready = 1'b0;
            endcase
        end
    end

    assign push = in_valid && in_ready && (state != DROP);
    assign pop  = |take;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // ------------------------------------------------------------------
    // Output channels
    // ------------------------------------------------------------------
    for (genvar k = 0; k < NOUT; k++) begin : g_lane
        osd_dii_demux_n_lane u_lane (
            .active     (streaming && (port_q == 2'(k))),
            .head_valid (!empty),
            .head_data  (head.data),
            .head_last  (head.last),
            .ready      (out_ready[k]),
            .valid      (out_valid[k]),
            .data       (out_data[16*k +: 16]),
            .last       (out_last[k]),
            .take       (take[k])
        );
    end

    // ------------------------------------------------------------------
    // Header buffer storage (no reset needed; guarded by count)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= '{data: in_data, last: in_last};
        end
    end

    // ------------------------------------------------------------------
    // Control FSM and buffer pointers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= COLLECT;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            port_q    <= '0;
            last_seen <= 1'b0;
        end else begin
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            count <= count + CW'(push) - CW'(pop);

            unique case (state)
                COLLECT: begin
                    if (push) begin
                        if (in_last) last_seen <= 1'b1;
                        if (at_sel) begin
                            port_q <= lut_port;
                            state  <= lut_drop ? DROP : STREAM;
                        end else if (in_last) begin
                            // Packet ended before the selector word.
                            port_q <= 2'(SHORT_PORT);
                            state  <= STREAM;
                        end
                    end
                end
                STREAM: begin
                    if (push && in_last) last_seen <= 1'b1;
                    if (pop && head.last) begin
                        state     <= COLLECT;
                        last_seen <= 1'b0;
                    end
                end
                DROP: begin
                    // Discard the buffered header at once; later flits
                    // are accepted and thrown away until the last one.
                    rd_ptr <= '0;
                    wr_ptr <= '0;
                    count  <= '0;
                    if (last_seen || (in_valid && in_ready && in_last)) begin
                        state     <= COLLECT;
                        last_seen <= 1'b0;
                    end
                end
                default: state <= COLLECT;
            endcase
        end
    end

`ifdef OSD_DEMUX_DROP_CNT_EN
    // ------------------------------------------------------------------
    // Saturating dropped-packet counter
    // ------------------------------------------------------------------
    logic enter_drop;
    assign enter_drop = (state == COLLECT) && push && at_sel && lut_drop;

    always_ff @(posedge clk) begin
        if (rst) begin
            drop_count <= '0;
        end else if (enter_drop && (drop_count != 16'hFFFF)) begin
            drop_count <= drop_count + 16'd1;
        end
    end
`endif

endmodule
